// File: rtl/core_pio_pkg.sv
// Shared definitions for the PIO input/output blocks.
package core_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/core_pio_sync.sv
// WIDTH x STAGES flop synchronizer for asynchronous inputs; stage 0 samples d.
module core_pio_sync #(
  parameter int WIDTH  = 10,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  // Shift the input through the chain; the last stage is the safe copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chain <= '0;
    else          chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/core_pio_in_edge.sv
// Avalon-MM input PIO with sticky edge capture and maskable level irq.
// Build option CORE_PIO_IN_BITCLR_EN: EDGE_CAPTURE writes clear only the
// bits written as 1; without it any write there clears every bit.
module core_pio_in_edge
  import core_pio_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] WARM = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_in, prev, edge_raw, edge_det, clr;
  logic [WIDTH-1:0] edge_capture, irq_mask;
  logic [2:0]       warm_cnt;
  logic             warm_done, wr, rd;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  core_pio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync_in)
  );

  // Previous synchronized sample for edge comparison.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= '0;
    else          prev <= sync_in;
  end

  // Warm-up: hold off edge detection until the chain and prev hold real input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        warm_cnt <= '0;
    else if (!warm_done) warm_cnt <= warm_cnt + 3'd1;
  end

  assign warm_done = (warm_cnt == WARM);

  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_raw = ~sync_in & prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edge_raw = sync_in ^ prev;
    end else begin : g_rise
      assign edge_raw = sync_in & ~prev;
    end
  endgenerate

  assign edge_det = warm_done ? edge_raw : '0;
  assign wr       = chipselect & ~write_n;
  assign rd       = chipselect & ~read_n;

`ifdef CORE_PIO_IN_BITCLR_EN
  assign clr = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
`else
  assign clr = {WIDTH{wr && address == ADDR_EDGE}};
`endif

  // Sticky capture: a new edge wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_capture <= '0;
    else          edge_capture <= (edge_capture & ~clr) | edge_det;
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      irq_mask <= '0;
    else if (wr && address == ADDR_MASK) irq_mask <= writedata[WIDTH-1:0];
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = sync_in;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
      default:   rd_mux = '0;
    endcase
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else if (rd)  readdata <= rd_mux;
  end

  // Registered level interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |(edge_capture & irq_mask);
  end

endmodule
